// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one uart_tx byte channel between N_REQ message sources. Arbitration
// is round-robin. Once a requester is granted, it keeps the channel until its
// byte flagged "last" is accepted, so messages never interleave on the wire.
// A watchdog takes the channel back from a granted requester that stops
// presenting bytes in the middle of a message.
//
// Handshake rule (all ports): a byte moves when valid and ready are both high
// at a rising clk edge. A source holds its data/last stable while valid is
// high and ready is low. Ready never depends on a later valid from the same
// side. tx_data/tx_data_valid come from a one-entry output register.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_data       : byte from requester i on [i*8 +: 8]
//   req_valid      : requester i presents a byte
//   req_last       : that byte ends requester i's message (qualified by valid)
//   req_ready      : byte from requester i accepted this cycle (combinational)
//   tx_data        : byte to uart_tx
//   tx_data_valid  : tx_data valid, held until tx_data_ready
//   tx_data_ready  : uart_tx accepts the byte
//   grant          : one-hot channel owner, zero when idle (registered)
//   abort          : one-cycle pulse when the watchdog revokes a grant
//   dbg_state      : FSM state (0 = IDLE, 1 = XFER)
//   dbg_ptr        : round-robin search start pointer (zero-extended)
//   dbg_last       : "last" flag of the byte in the output register
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ    = 3,
    parameter int IDLE_MAX = 27_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ*8-1:0] req_data,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_data_valid,
    input  logic               tx_data_ready,
    output logic [N_REQ-1:0]   grant,
    output logic               abort,
    output logic [1:0]         dbg_state,
    output logic [2:0]         dbg_ptr,
    output logic               dbg_last
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [31:0]        stall_q, stall_d;
    logic               abort_q, abort_d;
    logic               last_q;

    // Granted requester's signals, selected through the one-hot grant.
    logic [7:0]         sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic [PTR_W-1:0]   nxt_ptr;

    // Round-robin pick.
    logic [2*N_REQ-1:0] valid_dbl;
    logic [N_REQ-1:0]   valid_rot;
    logic               pick_found;
    logic [PTR_W:0]     pick_sum;
    logic [PTR_W-1:0]   pick_idx;
    logic [N_REQ-1:0]   pick_oh;

    logic               slot_free;
    logic               in_xfer;
    logic               load;
    logic               wd_fire;

    assign slot_free = !tx_data_valid || tx_data_ready;
    assign in_xfer   = (state_q == ST_XFER);
    assign load      = in_xfer && sel_valid && slot_free;
    assign wd_fire   = (IDLE_MAX != 0) && (stall_q >= 32'(IDLE_MAX));

    // Mux the granted requester. nxt_ptr is the index after the owner, so the
    // owner goes to the back of the round-robin order when it releases.
    always_comb begin
        sel_data  = 8'h00;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        nxt_ptr   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                sel_data  = req_data[i*8 +: 8];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                nxt_ptr   = (i == N_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Rotate the valids so bit 0 is the requester at ptr. The lowest set bit
    // of the rotated vector is the winner. Its offset is added back to ptr
    // and wrapped modulo N_REQ.
    always_comb begin
        valid_dbl  = {req_valid, req_valid};
        valid_rot  = N_REQ'(valid_dbl >> ptr_q);
        pick_found = 1'b0;
        pick_sum   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (valid_rot[i]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, ptr_q} + (PTR_W+1)'(i);
            end
        end
        if (pick_sum >= (PTR_W+1)'(N_REQ)) begin
            pick_sum = pick_sum - (PTR_W+1)'(N_REQ);
        end
        pick_idx = pick_sum[PTR_W-1:0];
        pick_oh  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pick_oh[i] = (pick_idx == PTR_W'(i));
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = in_xfer && grant_q[i] && req_valid[i] && slot_free;
        end
    end

    // Next-state logic. The grant changes only on entry to or exit from
    // XFER. A last handshake takes priority over the watchdog in the same
    // cycle.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_oh;
                    stall_d = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // Back-pressure from uart_tx (valid high, slot full) is not a
                // stall. Only a granted requester with no byte counts.
                if (load) begin
                    stall_d = '0;
                end else if (!sel_valid && (stall_q != 32'hFFFF_FFFF)) begin
                    stall_d = stall_q + 32'd1;
                end
                if (load && sel_last) begin
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                    state_d = ST_IDLE;
                end else if (wd_fire) begin
                    abort_d = 1'b1;
                    grant_d = '0;
                    ptr_d   = nxt_ptr;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            stall_q <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            abort_q <= abort_d;
        end
    end

    // Output register. A new load with tx_data_ready high replaces the byte
    // with no bubble. A byte still here after release or abort drains normally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data       <= 8'h00;
            tx_data_valid <= 1'b0;
            last_q        <= 1'b0;
        end else if (load) begin
            tx_data       <= sel_data;
            tx_data_valid <= 1'b1;
            last_q        <= sel_last;
        end else if (tx_data_valid && tx_data_ready) begin
            tx_data_valid <= 1'b0;
        end
    end

    assign grant     = grant_q;
    assign abort     = abort_q;
    assign dbg_state = state_q;
    assign dbg_ptr   = 3'(ptr_q);
    assign dbg_last  = last_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` byte channel between N independent message sources, such as the banner sender, the receive echo path and a status reporter. Arbitration is round-robin and message-locked. A requester keeps the grant from its first byte until its byte flagged `last` is accepted, so messages never interleave on the wire. A watchdog reclaims the channel from a granted requester that stalls mid-message. The block sits between the requesters and `uart_tx`, and drives `uart_tx`'s `tx_data`/`tx_data_valid` directly.

## Interface
- `N_REQ`, 3: number of requesters, 2..8.
- `IDLE_MAX`, 27_000_000: consecutive stall cycles (granted `req_valid` low) before the lock is revoked. 0 disables the watchdog.
- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_data` in N_REQ*8: byte from requester i on bits [i*8 +: 8].
- `req_valid` in N_REQ: requester i has a byte.
- `req_last` in N_REQ: the byte from requester i is the final byte of its message. Qualified by `req_valid`.
- `req_ready` out N_REQ: the byte from requester i is accepted this cycle. Combinational.
- `tx_data` out 8: byte to `uart_tx`.
- `tx_data_valid` out 1: `tx_data` is valid. Held until `tx_data_ready`.
- `tx_data_ready` in 1: `uart_tx` accepts the byte.
- `grant` out N_REQ: one-hot owner of the channel, all-zero when idle. Registered.
- `abort` out 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- The output stage is a one-entry register holding `tx_data`, `tx_data_valid` and internal `last_q`.
- Output slot free: `slot_free = !tx_data_valid || tx_data_ready`.
- States are IDLE and XFER.
- IDLE:
  - `grant` = 0 and `req_ready` = 0.
  - If any `req_valid` is high, pick the first set bit searching from pointer `ptr` upward, modulo N_REQ. Register its one-hot into `grant`, clear the stall counter and go to XFER.
- XFER, granted index g:
  - `req_ready[g] = req_valid[g] && slot_free`. All other `req_ready` bits are 0.
  - On a handshake on g, load `tx_data <= req_data[g]` and `tx_data_valid <= 1`, and clear the stall counter.
  - On a handshake with `req_last[g]` = 1, clear `grant`, set `ptr <= (g+1) mod N_REQ` and go to IDLE. The output byte still drains normally.
  - On `tx_data_valid && tx_data_ready` with no new load, `tx_data_valid <= 0`.
  - Stall counter: 32-bit. It increments on each XFER cycle with `req_valid[g]` = 0 and saturates.
  - When `IDLE_MAX` != 0 and the counter reaches `IDLE_MAX`, the block pulses `abort`, clears `grant`, sets `ptr <= g+1` and goes to IDLE. A byte already in the output register is still delivered.
- The grant changes only in IDLE. Requesters that raise `req_valid` during another requester's message wait.
- A requester with `req_valid` low in IDLE is skipped and loses nothing.
- A single active requester is re-granted after each message, with one IDLE cycle between messages.

## Timing
- Reset values:
  - `grant` = 0, `tx_data` = 8'h00, `tx_data_valid` = 0, `abort` = 0, `ptr` = 0, state IDLE, stall counter 0.
  - `req_ready` = 0 while `rst_n` is low.
- Reset mid-message drops the byte in the output register and the lock. `uart_tx` shares `rst_n`, so no partial state remains.
- Latency:
  - `req_valid` sampled high in IDLE at cycle n.
  - `grant` is high at n+1, and `req_ready` can be high at n+1.
  - `tx_data_valid` is high at n+2.
- Throughput: with `tx_data_ready` held at 1, one byte per cycle.
- Back-pressure: `tx_data` and `tx_data_valid` are stable while `tx_data_valid` = 1 and `tx_data_ready` = 0.
- Message gap: after a `last` handshake at cycle m, the next grant is registered at m+2, because m+1 is spent in IDLE.
- Simultaneous events:
  - A `last` handshake and the watchdog threshold in the same cycle are treated as a `last` handshake, and `abort` stays 0.
  - `tx_data_ready` together with a new load replaces the register with no bubble.

## Test plan
- Single requester, N_REQ=3: req1 sends "AB" with `last` on 'B', `tx_data_ready` = 1 → `grant` = 3'b010 at n+1; `tx_data` shows 8'h41 then 8'h42 on consecutive cycles; `grant` = 0 after 'B'; `ptr` = 2.
- Contention: req0, req1 and req2 all hold 2-byte messages from reset → wire order is the req0 pair, then req1, then req2, with no interleaving. Repeating the run gives the next order as req0, req1, req2 again, because `ptr` wraps 2→0.
- Back-pressure: `tx_data_ready` = 0 for 10 cycles with a byte loaded → `tx_data` and `tx_data_valid` hold, and `req_ready` = 0 throughout; the next byte is accepted in the same cycle `tx_data_ready` returns to 1.
- Watchdog, `IDLE_MAX` = 5: req2 sends one non-last byte, then drops `req_valid` → `abort` pulses for one cycle after 5 stall cycles; `grant` = 0; a waiting req0 is granted 1 cycle later.
- Reset mid-message: assert `rst_n` = 0 while `tx_data_valid` = 1 → `tx_data_valid`, `grant` and `req_ready` go to 0 immediately (asynchronously); after release, arbitration restarts from `ptr` = 0.
